apb_master_param: RTL

APB_MASTER_PARAM -- requirements
Module: apb_master_param

---
 rtl/apb_param_pkg.sv | 16 +
 rtl/apb_sel_decode.sv | 22 ++
 rtl/apb_master_param.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/apb_param_pkg.sv
// Shared definitions for the parameterised APB master: FSM state encoding
// and the default parameter values used by the top level.
package apb_param_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam int DEF_ADDR_W  = 9;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_NUM_SLV = 2;
   localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/apb_sel_decode.sv
// Maps an APB address plus a phase-active flag to a one-hot slave select.
// The slave index is taken from the top SEL_W address bits.
module apb_sel_decode #(
   parameter int ADDR_W  = 9,
   parameter int NUM_SLV = 2,
   parameter int SEL_W   = $clog2(NUM_SLV)
) (
   input  logic [ADDR_W-1:0]  i_addr,
   input  logic               i_active,
   output logic [NUM_SLV-1:0] o_psel,
   output logic [SEL_W-1:0]   o_idx
);

   always_comb begin
      o_idx  = i_addr[ADDR_W-1 -: SEL_W];
      o_psel = '0;
      if (i_active) begin
         o_psel = NUM_SLV'(1) << o_idx;
      end
   end

endmodule

// File: rtl/apb_master_param.sv
// Command/response to APB master bridge with per-slave select, registered APB
// outputs and an optional ACCESS-phase timeout.
module apb_master_param
   import apb_param_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int NUM_SLV = DEF_NUM_SLV,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                      PCLK,
   input  logic                      PRESET,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_W-1:0]         cmd_addr,
   input  logic [DATA_W-1:0]         cmd_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      rsp_timeout,
   output logic [NUM_SLV-1:0]        PSEL,
   output logic                      PENABLE,
   output logic [ADDR_W-1:0]         PADDR,
   output logic                      PWRITE,
   output logic [DATA_W-1:0]         PWDATA,
   input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
   input  logic [NUM_SLV-1:0]        PREADY,
   input  logic [NUM_SLV-1:0]        PSLVERR,
   output logic [1:0]                dbg_state
);

   localparam int SEL_W  = $clog2(NUM_SLV);
   localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

   apb_state_e          r_state;
   logic [WAIT_W-1:0]   r_wait;
   logic [SEL_W-1:0]    r_idx;

   apb_state_e          w_state_nxt;
   logic [WAIT_W-1:0]   w_wait_nxt;
   logic [ADDR_W-1:0]   w_paddr_nxt;
   logic                w_pwrite_nxt;
   logic [DATA_W-1:0]   w_pwdata_nxt;
   logic                w_penable_nxt;
   logic                w_rsp_valid_nxt;
   logic [DATA_W-1:0]   w_rsp_rdata_nxt;
   logic                w_rsp_err_nxt;
   logic                w_rsp_timeout_nxt;
   logic                w_sel_active;
   logic [NUM_SLV-1:0]  w_psel_nxt;
   logic [SEL_W-1:0]    w_idx_nxt;
   logic                w_rdy;
   logic [DATA_W-1:0]   w_rdata_sel;

   assign cmd_ready   = (r_state == ST_IDLE) && !rsp_valid;
   assign dbg_state   = r_state;
   assign w_rdy       = PREADY[r_idx];
   assign w_rdata_sel = PRDATA[r_idx*DATA_W +: DATA_W];

   // Decode from the next-state address so PSEL can be a plain register.
   assign w_sel_active = (w_state_nxt != ST_IDLE);

   apb_sel_decode #(
      .ADDR_W  (ADDR_W),
      .NUM_SLV (NUM_SLV),
      .SEL_W   (SEL_W)
   ) u_sel_decode (
      .i_addr   (w_paddr_nxt),
      .i_active (w_sel_active),
      .o_psel   (w_psel_nxt),
      .o_idx    (w_idx_nxt)
   );

   always_comb begin
      w_state_nxt       = r_state;
      w_wait_nxt        = r_wait;
      w_paddr_nxt       = PADDR;
      w_pwrite_nxt      = PWRITE;
      w_pwdata_nxt      = PWDATA;
      w_penable_nxt     = 1'b0;
      w_rsp_valid_nxt   = rsp_valid;
      w_rsp_rdata_nxt   = rsp_rdata;
      w_rsp_err_nxt     = rsp_err;
      w_rsp_timeout_nxt = rsp_timeout;

      if (rsp_valid && rsp_ready) begin
         w_rsp_valid_nxt = 1'b0;
      end

      case (r_state)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               w_paddr_nxt  = cmd_addr;
               w_pwrite_nxt = cmd_write;
               w_pwdata_nxt = cmd_wdata;
               w_wait_nxt   = '0;
               w_state_nxt  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            w_penable_nxt = 1'b1;
            w_state_nxt   = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (w_rdy) begin
               w_rsp_valid_nxt   = 1'b1;
               w_rsp_err_nxt     = PSLVERR[r_idx];
               w_rsp_timeout_nxt = 1'b0;
               w_rsp_rdata_nxt   = PWRITE ? '0 : w_rdata_sel;
               w_state_nxt       = ST_IDLE;
            end else begin
               w_wait_nxt = r_wait + 1'b1;
               // A ready on the final allowed cycle is handled above and wins.
               if ((TIMEOUT > 0) && (r_wait == WAIT_LAST)) begin
                  w_rsp_valid_nxt   = 1'b1;
                  w_rsp_err_nxt     = 1'b1;
                  w_rsp_timeout_nxt = 1'b1;
                  w_rsp_rdata_nxt   = '0;
                  w_state_nxt       = ST_IDLE;
               end else begin
                  w_penable_nxt = 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state     <= ST_IDLE;
         r_wait      <= '0;
         r_idx       <= '0;
         PSEL        <= '0;
         PENABLE     <= 1'b0;
         PADDR       <= '0;
         PWRITE      <= 1'b0;
         PWDATA      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_wait      <= w_wait_nxt;
         r_idx       <= w_idx_nxt;
         PSEL        <= w_psel_nxt;
         PENABLE     <= w_penable_nxt;
         PADDR       <= w_paddr_nxt;
         PWRITE      <= w_pwrite_nxt;
         PWDATA      <= w_pwdata_nxt;
         rsp_valid   <= w_rsp_valid_nxt;
         rsp_rdata   <= w_rsp_rdata_nxt;
         rsp_err     <= w_rsp_err_nxt;
         rsp_timeout <= w_rsp_timeout_nxt;
      end
   end

endmodule
